// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: pipeline control, memory-stage inputs and
// register-file writeback outputs. clk/reset stay plain ports.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [4:0]        in_rd;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic              in_link;
  logic [2:0]        in_load_type;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [DATA_W-1:0] in_pc_plus8;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic              regwrite;
  logic              wb_valid;
  logic [31:0]       retired_count;

  // Memory stage / pipeline control side
  modport master (
    output stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg,
           in_link, in_load_type, in_alu_result, in_mem_rdata, in_pc_plus8,
    input  write_reg, write_data, regwrite, wb_valid, retired_count
  );

  // MEM/WB register side
  modport slave (
    input  stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg,
           in_link, in_load_type, in_alu_result, in_mem_rdata, in_pc_plus8,
    output write_reg, write_data, regwrite, wb_valid, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load extraction, writeback
// source selection and a retired-instruction counter. All outputs come
// straight from flops; the selection logic sits in front of them.
module mem_wb_stage #(
  parameter int DATA_W           = 32,
  parameter bit ZERO_REG_PROTECT = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_value;
  logic [4:0]        wb_reg_nxt;
  logic [DATA_W-1:0] wb_data_nxt;
  logic              wb_we_nxt;

  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              regwrite_q;
  logic              wb_valid_q;
  logic [31:0]       retired_q;

  // Pick the addressed byte and halfword; offset 0 is the most significant lane.
  always_comb begin
    ld_byte = bus.in_mem_rdata[31:24];
    ld_half = bus.in_mem_rdata[31:16];
    case (bus.in_alu_result[1:0])
      2'd0:    ld_byte = bus.in_mem_rdata[31:24];
      2'd1:    ld_byte = bus.in_mem_rdata[23:16];
      2'd2:    ld_byte = bus.in_mem_rdata[15:8];
      default: ld_byte = bus.in_mem_rdata[7:0];
    endcase
    // Halfword uses only bit 1; an odd address is silently rounded down.
    if (bus.in_alu_result[1]) ld_half = bus.in_mem_rdata[15:0];
  end

  // Extend the selected lane by load type; unknown encodings behave as lw.
  always_comb begin
    ld_value = bus.in_mem_rdata;
    case (bus.in_load_type)
      LT_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_value = {24'd0, ld_byte};
      LT_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  ld_value = {16'd0, ld_half};
      default: ld_value = bus.in_mem_rdata;
    endcase
  end

  // Writeback source priority: link, then load, then ALU.
  always_comb begin
    wb_reg_nxt  = bus.in_link ? 5'd31 : bus.in_rd;
    wb_data_nxt = bus.in_alu_result;
    if (bus.in_link)          wb_data_nxt = bus.in_pc_plus8;
    else if (bus.in_memtoreg) wb_data_nxt = ld_value;
    wb_we_nxt = bus.in_valid & bus.in_regwrite;
    if (ZERO_REG_PROTECT && (wb_reg_nxt == 5'd0)) wb_we_nxt = 1'b0;
  end

  // Pipeline register: reset, then flush (bubble), then stall (hold), then capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      regwrite_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      retired_q    <= '0;
    end else if (bus.flush) begin
      regwrite_q <= 1'b0;
      wb_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      write_reg_q  <= wb_reg_nxt;
      write_data_q <= wb_data_nxt;
      regwrite_q   <= wb_we_nxt;
      wb_valid_q   <= bus.in_valid;
      if (bus.in_valid) retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.write_reg     = write_reg_q;
  assign bus.write_data    = write_data_q;
  assign bus.regwrite      = regwrite_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. A second instance with register-0
// protection enabled shares the same stimulus.
module tb_mem_wb_stage;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  logic [31:0] exp_cnt;

  mem_wb_stage_if #(.DATA_W(32)) bus0 ();
  mem_wb_stage_if #(.DATA_W(32)) bus1 ();

  mem_wb_stage #(.DATA_W(32), .ZERO_REG_PROTECT(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  mem_wb_stage #(.DATA_W(32), .ZERO_REG_PROTECT(1'b1)) dut_zrp (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  assign bus1.stall         = bus0.stall;
  assign bus1.flush         = bus0.flush;
  assign bus1.in_valid      = bus0.in_valid;
  assign bus1.in_rd         = bus0.in_rd;
  assign bus1.in_regwrite   = bus0.in_regwrite;
  assign bus1.in_memtoreg   = bus0.in_memtoreg;
  assign bus1.in_link       = bus0.in_link;
  assign bus1.in_load_type  = bus0.in_load_type;
  assign bus1.in_alu_result = bus0.in_alu_result;
  assign bus1.in_mem_rdata  = bus0.in_mem_rdata;
  assign bus1.in_pc_plus8   = bus0.in_pc_plus8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic lnk, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc8);
    bus0.in_valid      = v;
    bus0.in_rd         = rd;
    bus0.in_regwrite   = rw;
    bus0.in_memtoreg   = m2r;
    bus0.in_link       = lnk;
    bus0.in_load_type  = lt;
    bus0.in_alu_result = alu;
    bus0.in_mem_rdata  = rdata;
    bus0.in_pc_plus8   = pc8;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] wr, input logic [31:0] wd,
                         input logic we, input logic wv, input logic [31:0] cnt);
    chk({tag, ".write_reg"},  {27'd0, bus0.write_reg}, {27'd0, wr});
    chk({tag, ".write_data"}, bus0.write_data, wd);
    chk({tag, ".regwrite"},   {31'd0, bus0.regwrite}, {31'd0, we});
    chk({tag, ".wb_valid"},   {31'd0, bus0.wb_valid}, {31'd0, wv});
    chk({tag, ".count"},      bus0.retired_count, cnt);
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[10];

  initial begin
    n_vec = 0;
    n_miss = 0;
    exp_cnt = 0;
    reset = 1'b0;
    bus0.stall = 1'b0;
    bus0.flush = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);

    ld_tab[0] = '{3'd1, 32'h0000_1000, 32'hFFFF_FF80};
    ld_tab[1] = '{3'd2, 32'h0000_1000, 32'h0000_0080};
    ld_tab[2] = '{3'd1, 32'h0000_1002, 32'h0000_007F};
    ld_tab[3] = '{3'd3, 32'h0000_1002, 32'h0000_7F01};
    ld_tab[4] = '{3'd4, 32'h0000_1000, 32'h0000_80FF};
    ld_tab[5] = '{3'd6, 32'h0000_1003, 32'h80FF_7F01};
    ld_tab[6] = '{3'd1, 32'h0000_1003, 32'h0000_0001};
    ld_tab[7] = '{3'd2, 32'h0000_1001, 32'h0000_00FF};
    ld_tab[8] = '{3'd3, 32'h0000_1001, 32'hFFFF_80FF};
    ld_tab[9] = '{3'd4, 32'h0000_1003, 32'h0000_7F01};

    // Reset state, with an edge passing while reset is held
    step();
    chk_all("reset", 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);

    // Release at a falling edge; first capture is an ALU op
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0);
    step();
    exp_cnt = 1;
    chk_all("alu", 5'd5, 32'h1234_5678, 1'b1, 1'b1, exp_cnt);

    // Load extraction table
    foreach (ld_tab[i]) begin
      @(negedge clk);
      set_in(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, ld_tab[i].lt, ld_tab[i].alu, 32'h80FF_7F01, 32'h0);
      step();
      exp_cnt++;
      chk($sformatf("load%0d.data", i), bus0.write_data, ld_tab[i].exp);
      chk($sformatf("load%0d.count", i), bus0.retired_count, exp_cnt);
    end

    // load_type ignored when not a load
    @(negedge clk);
    set_in(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
    step();
    exp_cnt++;
    chk("nomem.data", bus0.write_data, 32'h0000_1000);

    // Link beats memtoreg and forces r31
    @(negedge clk);
    set_in(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0048);
    step();
    exp_cnt++;
    chk_all("link", 5'd31, 32'h0000_0048, 1'b1, 1'b1, exp_cnt);

    // Stall three cycles with different inputs presented: everything holds
    @(negedge clk);
    bus0.stall = 1'b1;
    set_in(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 5'd31, 32'h0000_0048, 1'b1, 1'b1, exp_cnt);
    end

    // Stall and flush together: bubble, data/reg hold, no increment
    @(negedge clk);
    bus0.flush = 1'b1;
    step();
    chk_all("stall_flush", 5'd31, 32'h0000_0048, 1'b0, 1'b0, exp_cnt);

    // Flush alone with a valid entry offered
    @(negedge clk);
    bus0.stall = 1'b0;
    step();
    chk_all("flush", 5'd31, 32'h0000_0048, 1'b0, 1'b0, exp_cnt);

    // in_valid=0 with in_regwrite=1: captured but no write, no count
    @(negedge clk);
    bus0.flush = 1'b0;
    set_in(1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_00C3, 32'h0, 32'h0);
    step();
    chk_all("invalid", 5'd12, 32'h0000_00C3, 1'b0, 1'b0, exp_cnt);

    // Destination r0: default instance writes, protected instance does not
    @(negedge clk);
    set_in(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
    step();
    exp_cnt++;
    chk("r0.regwrite", {31'd0, bus0.regwrite}, 32'd1);
    chk("r0zrp.regwrite", {31'd0, bus1.regwrite}, 32'd0);
    chk("r0zrp.wb_valid", {31'd0, bus1.wb_valid}, 32'd1);
    chk("r0zrp.count", bus1.retired_count, exp_cnt);

    // Link on the protected instance targets r31, so it still writes
    @(negedge clk);
    set_in(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0000_0100);
    step();
    exp_cnt++;
    chk("r0zrp_link.regwrite", {31'd0, bus1.regwrite}, 32'd1);

    // Asynchronous reset between edges while stalling
    @(negedge clk);
    set_in(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0333, 32'h0, 32'h0);
    step();
    exp_cnt++;
    chk_all("pre_areset", 5'd3, 32'h0000_0333, 1'b1, 1'b1, exp_cnt);
    bus0.stall = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk_all("areset", 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
    chk("areset_zrp.count", bus1.retired_count, 32'd0);
    bus0.flush = 1'b1;
    step();
    chk_all("areset_held", 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);

    // First capture after release counts 1
    @(negedge clk);
    reset = 1'b1;
    bus0.stall = 1'b0;
    bus0.flush = 1'b0;
    set_in(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0444, 32'h0, 32'h0);
    step();
    exp_cnt = 1;
    chk_all("post_reset", 5'd4, 32'h0000_0444, 1'b1, 1'b1, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "bench timeout");
  end

endmodule
